control_multiciclo: RTL and testbench
=====================================

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 The block SHALL expose parameter MEM_WAIT_MAX, default 8, as the maximum number of MEM-state cycles tolerated without mem_ready.
REQ-002 The block SHALL expose port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL expose port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL expose port instr_valid, input, 1, instruction word offered.
REQ-005 The block SHALL expose port instr, input, 32, RV32I instruction word.
REQ-006 The block SHALL expose port mem_ready, input, 1, data-memory access complete.
REQ-007 The block SHALL expose port branch_taken, input, 1, branch comparison result from the ALU, sampled in EXECUTE.
REQ-008 The block SHALL expose port instr_ready, output, 1, block can accept an instruction.
REQ-009 The block SHALL expose port inmediato, output, 12, immediate field routed to the sign extender.
REQ-010 The block SHALL expose outputs alu_src_imm, alu_start, mem_re, mem_we, reg_we, pc_we, branch_sel and trap, each 1 bit, as datapath strobes.
REQ-011 The block SHALL expose port estado, output, 3, current FSM state code.

Function
REQ-012 The block SHALL implement states IDLE=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4 and TRAP=5; codes 6-7 SHALL go to TRAP.
REQ-013 All outputs SHALL be driven only by registered state, the latched instruction and the registered counter, with no combinational path from inputs to outputs.
REQ-014 In IDLE, instr_ready SHALL be 1; when instr_valid and instr_ready are both 1 on an edge, instr SHALL be latched into IR and the FSM SHALL go to DECODE.
REQ-015 instr_ready SHALL be 0 in every state other than IDLE, and instr_valid SHALL be ignored outside IDLE.
REQ-016 In DECODE, opcode IR[6:0] SHALL classify the instruction as follows: 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 0110011 OP, 1100011 BRANCH.
REQ-017 In DECODE, any other opcode SHALL cause a transition to TRAP; otherwise the FSM SHALL go to EXECUTE.
REQ-018 The inmediato register SHALL be loaded in DECODE and held until the next DECODE, using these selections.
- I-type (OP-IMM, LOAD): IR[31:20].
- S-type: {IR[31:25], IR[11:7]}.
- B-type: {IR[31], IR[7], IR[30:25], IR[11:8]}.
- OP: 12'h000.
REQ-019 alu_src_imm SHALL be 1 for OP-IMM, LOAD and STORE, and 0 otherwise, from DECODE through WRITEBACK.
REQ-020 alu_start SHALL be a single-cycle pulse, 1 only in EXECUTE.
REQ-021 From EXECUTE, LOAD and STORE SHALL go to MEM; all other classes SHALL go to WRITEBACK.
REQ-022 For BRANCH, branch_sel SHALL capture branch_taken in EXECUTE and hold it through WRITEBACK.
REQ-023 In MEM, mem_re (LOAD) or mem_we (STORE) SHALL be held at 1 until mem_ready is sampled 1, then the FSM SHALL go to WRITEBACK.
REQ-024 A wait counter SHALL start at 0 on MEM entry and increment each MEM cycle without mem_ready.
REQ-025 When the counter reaches MEM_WAIT_MAX without mem_ready, the FSM SHALL go to TRAP; mem_ready in that same cycle SHALL win and go to WRITEBACK.
REQ-026 WRITEBACK SHALL last exactly 1 cycle with pc_we=1, and reg_we=1 only for OP, OP-IMM and LOAD; the FSM SHALL then go to IDLE.
REQ-027 TRAP SHALL be sticky until rst: trap=1, instr_ready=0 and all other strobes 0.
REQ-028 Latency from the accept edge to instr_ready=1 again SHALL be 4 cycles for OP, OP-IMM and BRANCH, and 5+N cycles for LOAD/STORE, where N is the number of extra mem_ready wait cycles.

Reset
REQ-029 When rst=1, the block SHALL enter IDLE immediately, including mid-MEM, with IR and inmediato cleared to 0, the counter at 0, instr_ready=1, and all other outputs at 0.
REQ-030 When rst is deasserted, no instruction SHALL be accepted before the first rising edge after deassertion.

Verification
REQ-031 addi x1,x0,-1 (0xFFF00093): inmediato=12'hFFF, alu_src_imm=1, alu_start in cycle 2, reg_we and pc_we in cycle 3, instr_ready=1 in cycle 4.
REQ-032 sw x2,-4(x1) (0xFE20AE23) with mem_ready delayed 3 cycles: inmediato=12'hFFC, mem_we high 4 cycles, reg_we=0, pc_we=1 once.
REQ-033 beq with offset -8 (0xFE000CE3) and branch_taken=1: inmediato=12'hFFC (imm[12:1]), branch_sel=1 in WRITEBACK.
REQ-034 Load with mem_ready never asserted: TRAP after MEM_WAIT_MAX=8 cycles and trap=1 until rst; a subsequent instr_valid is ignored.
REQ-035 Opcode 0x7F: TRAP from DECODE; rst pulsed mid-MEM on a second run: estado=0 and mem_re=0 asynchronously.

Source files
------------

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: IDLE -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK, sticky TRAP on errors.
// Latency 4 cycles (OP/OP-IMM/BRANCH), 5+N for LOAD/STORE; instr_ready only in IDLE, MEM waits on mem_ready.
module control_multiciclo #(
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        instr_ready,
  output logic [11:0] inmediato,
  output logic        alu_src_imm,
  output logic        alu_start,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        branch_sel,
  output logic        trap,
  output logic [2:0]  estado
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   ir;
  logic [11:0]   imm_q;
  logic [CW-1:0] cnt;
  logic          bsel_q;

  logic is_opimm, is_load, is_store, is_op, is_branch, is_legal;
  logic unused_ir_bits;

  assign is_opimm  = (ir[6:0] == 7'b0010011);
  assign is_load   = (ir[6:0] == 7'b0000011);
  assign is_store  = (ir[6:0] == 7'b0100011);
  assign is_op     = (ir[6:0] == 7'b0110011);
  assign is_branch = (ir[6:0] == 7'b1100011);
  assign is_legal  = is_opimm | is_load | is_store | is_op | is_branch;

  // rs1/funct3 are consumed by the datapath, not by this controller
  assign unused_ir_bits = ^ir[19:12];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (instr_valid) state_nxt = DECODE;
      DECODE:    state_nxt = is_legal ? EXECUTE : TRAP;
      EXECUTE:   state_nxt = (is_load | is_store) ? MEM : WRITEBACK;
      MEM: begin
        // mem_ready takes priority over the timeout in the final wait cycle
        if (mem_ready)                          state_nxt = WRITEBACK;
        else if (cnt == CW'(MEM_WAIT_MAX - 1))  state_nxt = TRAP;
      end
      WRITEBACK: state_nxt = IDLE;
      TRAP:      state_nxt = TRAP;
      default:   state_nxt = TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      imm_q  <= '0;
      cnt    <= '0;
      bsel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == DECODE) begin
        bsel_q <= 1'b0;
        if (is_opimm || is_load)  imm_q <= ir[31:20];
        else if (is_store)        imm_q <= {ir[31:25], ir[11:7]};
        else if (is_branch)       imm_q <= {ir[31], ir[7], ir[30:25], ir[11:8]};
        else                      imm_q <= 12'h000;
      end
      if (state == EXECUTE && is_branch) bsel_q <= branch_taken;
      if (state == MEM && !mem_ready) cnt <= cnt + CW'(1);
      else                            cnt <= '0;
    end
  end

  always_comb begin
    instr_ready = (state == IDLE);
    alu_src_imm = 1'b0;
    alu_start   = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    branch_sel  = 1'b0;
    trap        = (state == TRAP);
    case (state)
      DECODE, EXECUTE, MEM, WRITEBACK: alu_src_imm = is_opimm | is_load | is_store;
      default: ;
    endcase
    case (state)
      EXECUTE: alu_start = 1'b1;
      MEM: begin
        mem_re = is_load;
        mem_we = is_store;
      end
      WRITEBACK: begin
        pc_we      = 1'b1;
        reg_we     = is_op | is_opimm | is_load;
        branch_sel = bsel_q;
      end
      default: ;
    endcase
  end

  assign inmediato = imm_q;
  assign estado    = state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: expected per-cycle outputs queued with each stimulus step,
// then popped and compared one time unit after the clock edge.
module tb_control_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        instr_ready;
  logic [11:0] inmediato;
  logic        alu_src_imm, alu_start, mem_re, mem_we, reg_we, pc_we, branch_sel, trap;
  logic [2:0]  estado;

  control_multiciclo #(.MEM_WAIT_MAX(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .instr_ready(instr_ready),
    .inmediato(inmediato), .alu_src_imm(alu_src_imm), .alu_start(alu_start),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .pc_we(pc_we),
    .branch_sel(branch_sel), .trap(trap), .estado(estado)
  );

  always #5 clk = ~clk;

  // strobe order: alu_src_imm alu_start mem_re mem_we reg_we pc_we branch_sel trap
  typedef struct packed {
    logic [2:0]  st;
    logic        rdy;
    logic [11:0] imm;
    logic [7:0]  strb;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string step  = "reset";

  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] SW   = 32'hFE20AE23;
  localparam logic [31:0] BEQ  = 32'hFE000CE3;
  localparam logic [31:0] LW   = 32'h0080A183;
  localparam logic [31:0] BAD  = 32'h0000007F;

  function automatic exp_t mk(input logic [2:0] st, input logic rdy,
                              input logic [11:0] imm, input logic [7:0] strb);
    exp_t e;
    e.st = st; e.rdy = rdy; e.imm = imm; e.strb = strb;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s/scoreboard: observed empty queue expected entry", step);
      return;
    end
    e = sb.pop_front();
    chk("estado", 32'(estado), 32'(e.st));
    chk("instr_ready", 32'(instr_ready), 32'(e.rdy));
    chk("inmediato", 32'(inmediato), 32'(e.imm));
    chk("strobes", 32'({alu_src_imm, alu_start, mem_re, mem_we, reg_we, pc_we, branch_sel, trap}),
        32'(e.strb));
  endtask

  task automatic cyc(input logic v, input logic [31:0] i, input logic mr, input logic bt,
                     input exp_t e);
    instr_valid = v; instr = i; mem_ready = mr; branch_taken = bt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(3'd0, 1'b1, 12'h000, 8'b0000_0000));
    check_out();
    rst = 1'b0;

    step = "addi";
    cyc(1, ADDI, 0, 0, mk(3'd1, 0, 12'h000, 8'b1000_0000));
    cyc(0, 0,    0, 0, mk(3'd2, 0, 12'hFFF, 8'b1100_0000));
    cyc(0, 0,    0, 0, mk(3'd4, 0, 12'hFFF, 8'b1000_1100));
    cyc(0, 0,    0, 0, mk(3'd0, 1, 12'hFFF, 8'b0000_0000));

    step = "sw";
    cyc(1, SW,   1, 0, mk(3'd1, 0, 12'hFFF, 8'b1000_0000));
    cyc(1, ADDI, 0, 0, mk(3'd2, 0, 12'hFFC, 8'b1100_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'hFFC, 8'b1001_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'hFFC, 8'b1001_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'hFFC, 8'b1001_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'hFFC, 8'b1001_0000));
    cyc(0, 0,    1, 0, mk(3'd4, 0, 12'hFFC, 8'b1000_0100));
    cyc(0, 0,    0, 0, mk(3'd0, 1, 12'hFFC, 8'b0000_0000));

    step = "beq";
    cyc(1, BEQ,  0, 0, mk(3'd1, 0, 12'hFFC, 8'b0000_0000));
    cyc(0, 0,    0, 0, mk(3'd2, 0, 12'hFFC, 8'b0100_0000));
    cyc(0, 0,    0, 1, mk(3'd4, 0, 12'hFFC, 8'b0000_0110));
    cyc(0, 0,    0, 0, mk(3'd0, 1, 12'hFFC, 8'b0000_0000));

    step = "lw_timeout";
    cyc(1, LW,   0, 0, mk(3'd1, 0, 12'hFFC, 8'b1000_0000));
    cyc(0, 0,    0, 0, mk(3'd2, 0, 12'h008, 8'b1100_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'h008, 8'b1010_0000));
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, mk(3'd3, 0, 12'h008, 8'b1010_0000));
    cyc(0, 0,    0, 0, mk(3'd5, 0, 12'h008, 8'b0000_0001));
    step = "trap_sticky";
    cyc(1, ADDI, 1, 1, mk(3'd5, 0, 12'h008, 8'b0000_0001));
    cyc(1, ADDI, 0, 0, mk(3'd5, 0, 12'h008, 8'b0000_0001));

    rst = 1'b1;
    #1;
    step = "rst_from_trap";
    sb.push_back(mk(3'd0, 1, 12'h000, 8'b0000_0000));
    check_out();
    @(posedge clk);
    #1 rst = 1'b0;

    step = "lw_ready_at_limit";
    cyc(1, LW,   0, 0, mk(3'd1, 0, 12'h000, 8'b1000_0000));
    cyc(0, 0,    0, 0, mk(3'd2, 0, 12'h008, 8'b1100_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'h008, 8'b1010_0000));
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, mk(3'd3, 0, 12'h008, 8'b1010_0000));
    cyc(0, 0,    1, 0, mk(3'd4, 0, 12'h008, 8'b1000_1100));
    cyc(0, 0,    0, 0, mk(3'd0, 1, 12'h008, 8'b0000_0000));

    step = "illegal";
    cyc(1, BAD,  0, 0, mk(3'd1, 0, 12'h008, 8'b0000_0000));
    cyc(0, 0,    0, 0, mk(3'd5, 0, 12'h000, 8'b0000_0001));
    cyc(0, 0,    1, 0, mk(3'd5, 0, 12'h000, 8'b0000_0001));

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    step = "rst_mid_mem";
    cyc(1, LW,   0, 0, mk(3'd1, 0, 12'h000, 8'b1000_0000));
    cyc(0, 0,    0, 0, mk(3'd2, 0, 12'h008, 8'b1100_0000));
    cyc(0, 0,    0, 0, mk(3'd3, 0, 12'h008, 8'b1010_0000));
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk(3'd0, 1, 12'h000, 8'b0000_0000));
    check_out();
    @(posedge clk);
    #1 rst = 1'b0;
    step = "after_rst";
    cyc(0, 0,    0, 0, mk(3'd0, 1, 12'h000, 8'b0000_0000));
    cyc(1, ADDI, 0, 0, mk(3'd1, 0, 12'h000, 8'b1000_0000));
    cyc(0, 0,    0, 0, mk(3'd2, 0, 12'hFFF, 8'b1100_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
